// File: rtl/io_port_fl.sv
// io_port_fl: processor I/O port block.
// Each input port has a one-entry buffer that producers fill through a
// valid/ready handshake and the processor reads with zero latency. Output
// ports are registered words, each with a one-cycle valid pulse per write.
// Reading an empty input port returns the stale word and sets a sticky
// underrun flag.
// Optional build macro IO_PORT_UNDERRUN_CNT_EN adds an 8-bit saturating
// count of underrun events on port underrun_cnt.
module io_port_fl #(
    parameter int NBMANT = 16,
    parameter int NBEXPO = 6,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8,
    localparam int NBW = NBMANT + NBEXPO + 1,
    localparam int AIW = $clog2(NUIOIN),
    localparam int AOW = $clog2(NUIOOU)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_in,
    input  logic [AIW-1:0]          addr_in,
    output logic [NBW-1:0]          io_in,
    input  logic                    out_en,
    input  logic [AOW-1:0]          addr_out,
    input  logic [NBW-1:0]          io_out,
    input  logic [NUIOIN*NBW-1:0]   in_data,
    input  logic [NUIOIN-1:0]       in_valid,
    output logic [NUIOIN-1:0]       in_ready,
    output logic [NUIOOU*NBW-1:0]   out_data,
    output logic [NUIOOU-1:0]       out_valid,
    output logic [NUIOIN-1:0]       underrun
`ifdef IO_PORT_UNDERRUN_CNT_EN
    ,
    output logic [7:0]              underrun_cnt
`endif
);

    logic [NBW-1:0]    buf_q   [NUIOIN];
    logic [NBW-1:0]    buf_d   [NUIOIN];
    logic [NUIOIN-1:0] full_q, full_d;
    logic [NUIOIN-1:0] under_q, under_d;
    logic [NUIOIN-1:0] consume;
    logic [NBW-1:0]    odata_q [NUIOOU];
    logic [NBW-1:0]    odata_d [NUIOOU];
    logic [NUIOOU-1:0] oval_q, oval_d;

    // Processor read strobe decode and producer-side ready; a word being
    // consumed this cycle frees the slot for a same-cycle refill.
    always_comb begin
        consume  = '0;
        in_ready = '0;
        for (int i = 0; i < NUIOIN; i++) begin
            consume[i]  = ~rst & req_in & (int'(addr_in) == i);
            in_ready[i] = ~rst & (~full_q[i] | consume[i]);
        end
    end

    // Zero-latency read mux; out-of-range addresses fall through to zero.
    always_comb begin
        io_in = '0;
        for (int i = 0; i < NUIOIN; i++) begin
            if (int'(addr_in) == i) io_in = buf_q[i];
        end
    end

    // Next state of input buffers, full flags and sticky underrun flags.
    always_comb begin
        buf_d   = buf_q;
        full_d  = full_q;
        under_d = under_q;
        for (int i = 0; i < NUIOIN; i++) begin
            if (in_valid[i] & in_ready[i]) begin
                buf_d[i]  = in_data[i*NBW +: NBW];
                full_d[i] = 1'b1;
            end else if (consume[i]) begin
                full_d[i] = 1'b0;
            end
            if (consume[i] & ~full_q[i]) under_d[i] = 1'b1;
        end
    end

    // Next state of output words and their one-cycle valid pulses.
    always_comb begin
        odata_d = odata_q;
        oval_d  = '0;
        for (int j = 0; j < NUIOOU; j++) begin
            if (out_en & ~rst & (int'(addr_out) == j)) begin
                odata_d[j] = io_out;
                oval_d[j]  = 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q   <= '{default: '0};
            full_q  <= '0;
            under_q <= '0;
            odata_q <= '{default: '0};
            oval_q  <= '0;
        end else begin
            buf_q   <= buf_d;
            full_q  <= full_d;
            under_q <= under_d;
            odata_q <= odata_d;
            oval_q  <= oval_d;
        end
    end

    // Output packing.
    always_comb begin
        out_data = '0;
        for (int j = 0; j < NUIOOU; j++) begin
            out_data[j*NBW +: NBW] = odata_q[j];
        end
    end

    assign out_valid = oval_q;
    assign underrun  = under_q;

`ifdef IO_PORT_UNDERRUN_CNT_EN
    logic [7:0] ucnt_q, ucnt_d;

    // Saturating underrun event count; at most one read per cycle, so at
    // most one event per cycle.
    always_comb begin
        ucnt_d = ucnt_q;
        if (|(consume & ~full_q) && (ucnt_q != 8'hFF)) ucnt_d = ucnt_q + 8'd1;
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) ucnt_q <= '0;
        else     ucnt_q <= ucnt_d;
    end

    assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_io_port_fl.sv
// Self-checking bench for io_port_fl: directed scenarios followed by random
// traffic, all compared against a per-port behavioural model.
module tb_io_port_fl;
    localparam int NBMANT = 16;
    localparam int NBEXPO = 6;
    localparam int NUIOIN = 8;
    localparam int NUIOOU = 8;
    localparam int NBW = NBMANT + NBEXPO + 1;
    localparam int AIW = $clog2(NUIOIN);
    localparam int AOW = $clog2(NUIOOU);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_in;
    logic [AIW-1:0]        addr_in;
    logic [NBW-1:0]        io_in;
    logic                  out_en;
    logic [AOW-1:0]        addr_out;
    logic [NBW-1:0]        io_out;
    logic [NUIOIN*NBW-1:0] in_data;
    logic [NUIOIN-1:0]     in_valid;
    logic [NUIOIN-1:0]     in_ready;
    logic [NUIOOU*NBW-1:0] out_data;
    logic [NUIOOU-1:0]     out_valid;
    logic [NUIOIN-1:0]     underrun;
`ifdef IO_PORT_UNDERRUN_CNT_EN
    logic [7:0]            underrun_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Model state
    logic [NBW-1:0]    mbuf  [NUIOIN];
    logic [NUIOIN-1:0] mfull;
    logic [NUIOIN-1:0] munder;
    logic [NBW-1:0]    mout  [NUIOOU];
    logic [NUIOOU-1:0] mvalid;
    int                mcnt;

    io_port_fl #(.NBMANT(NBMANT), .NBEXPO(NBEXPO), .NUIOIN(NUIOIN), .NUIOOU(NUIOOU)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .addr_in(addr_in), .io_in(io_in),
        .out_en(out_en), .addr_out(addr_out), .io_out(io_out),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .underrun(underrun)
`ifdef IO_PORT_UNDERRUN_CNT_EN
        , .underrun_cnt(underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUIOIN; i++) mbuf[i] = '0;
        for (int j = 0; j < NUIOOU; j++) mout[j] = '0;
        mfull = '0; munder = '0; mvalid = '0; mcnt = 0;
    endtask

    task automatic idle_inputs();
        req_in = 1'b0; addr_in = '0; out_en = 1'b0; addr_out = '0; io_out = '0;
        in_data = '0; in_valid = '0; rst = 1'b0;
    endtask

    // One clock: check combinational outputs, advance model, check registers.
    task automatic step();
        logic [NUIOIN-1:0]     exp_ready;
        logic [NBW-1:0]        exp_io;
        logic [NUIOOU*NBW-1:0] exp_od;
        bit                    rd;
        int                    a;
        #1;
        a  = int'(addr_in);
        rd = !rst && req_in && (a < NUIOIN);
        exp_io = (a < NUIOIN) ? mbuf[a] : '0;
        for (int i = 0; i < NUIOIN; i++)
            exp_ready[i] = !rst && (!mfull[i] || (rd && a == i));
        check("io_in", io_in, exp_io);
        check("in_ready", in_ready, exp_ready);
        if (rst) begin
            model_clear();
        end else begin
            if (rd && !mfull[a]) begin
                munder[a] = 1'b1;
                if (mcnt < 255) mcnt++;
            end
            for (int i = 0; i < NUIOIN; i++) begin
                if (in_valid[i] && exp_ready[i]) begin
                    mbuf[i]  = in_data[i*NBW +: NBW];
                    mfull[i] = 1'b1;
                end else if (rd && a == i) begin
                    mfull[i] = 1'b0;
                end
            end
            mvalid = '0;
            if (out_en && int'(addr_out) < NUIOOU) begin
                mout[addr_out]   = io_out;
                mvalid[addr_out] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        exp_od = '0;
        for (int j = 0; j < NUIOOU; j++) exp_od[j*NBW +: NBW] = mout[j];
        check("out_valid", out_valid, mvalid);
        check("out_data", out_data, exp_od);
        check("underrun", underrun, munder);
`ifdef IO_PORT_UNDERRUN_CNT_EN
        check("underrun_cnt", underrun_cnt, mcnt[7:0]);
`endif
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        #1;
        check("reset_io_in", io_in, 0);
        check("reset_in_ready", in_ready, 8'hFF);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_underrun", underrun, 0);

        // Load port 2, then read it.
        idle_inputs();
        in_valid[2] = 1'b1; in_data[2*NBW +: NBW] = 23'h12345A;
        step();
        idle_inputs();
        req_in = 1'b1; addr_in = 3'd2;
        #1;
        check("p2_read_data", io_in, 23'h12345A);
        step();
        idle_inputs();
        #1;
        check("p2_ready_after", in_ready[2], 1'b1);
        step();

        // Port 5: consume and refill in the same cycle.
        in_valid[5] = 1'b1; in_data[5*NBW +: NBW] = 23'h000111;
        step();
        req_in = 1'b1; addr_in = 3'd5; in_data[5*NBW +: NBW] = 23'h000222;
        #1;
        check("p5_ready_refill", in_ready[5], 1'b1);
        step();
        idle_inputs();
        addr_in = 3'd5;
        #1;
        check("p5_new_word", io_in, 23'h000222);
        check("p5_still_full", in_ready[5], 1'b0);
        step();

        // Port 3: one word consumed, then a read of the empty port.
        in_valid[3] = 1'b1; in_data[3*NBW +: NBW] = 23'h0000AA;
        step();
        idle_inputs();
        req_in = 1'b1; addr_in = 3'd3;
        step();
        #1;
        check("p3_stale_word", io_in, 23'h0000AA);
        step();
        check("p3_underrun_set", underrun[3], 1'b1);
        idle_inputs();
        repeat (3) step();
        check("p3_underrun_sticky", underrun[3], 1'b1);
`ifdef IO_PORT_UNDERRUN_CNT_EN
        check("p3_cnt_one", underrun_cnt, 8'd1);
`endif

        // Output write to port 6.
        out_en = 1'b1; addr_out = 3'd6; io_out = 23'h7FFFFF;
        step();
        check("p6_pulse", out_valid, 8'h40);
        check("p6_word", out_data[6*NBW +: NBW], 23'h7FFFFF);
        idle_inputs();
        step();
        check("p6_pulse_end", out_valid, 8'h00);
        check("p6_word_held", out_data[6*NBW +: NBW], 23'h7FFFFF);

        // Back-to-back writes to port 1.
        out_en = 1'b1; addr_out = 3'd1; io_out = 23'h00ABCD;
        step();
        io_out = 23'h055555;
        step();
        check("p1_b2b_pulse", out_valid, 8'h02);
        check("p1_b2b_word", out_data[1*NBW +: NBW], 23'h055555);

        // Reset with port 0 full and output word 1 nonzero.
        idle_inputs();
        in_valid[0] = 1'b1; in_data[0 +: NBW] = 23'h0F0F0F;
        step();
        idle_inputs();
        rst = 1'b1; req_in = 1'b1; out_en = 1'b1; addr_out = 3'd2; io_out = 23'h1;
        #1;
        check("rst_ready_low", in_ready, 8'h00);
        step();
        idle_inputs();
        #1;
        check("post_rst_ready", in_ready, 8'hFF);
        check("post_rst_out_data", out_data, 0);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_underrun", underrun, 0);
        check("post_rst_io_in", io_in, 0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 49) == 0);
            req_in   = $urandom_range(0, 1);
            addr_in  = AIW'($urandom_range(0, NUIOIN - 1));
            in_valid = NUIOIN'($urandom);
            for (int i = 0; i < NUIOIN; i++) in_data[i*NBW +: NBW] = NBW'($urandom);
            out_en   = $urandom_range(0, 1);
            addr_out = AOW'($urandom_range(0, NUIOOU - 1));
            io_out   = NBW'($urandom);
            step();
        end

        // Long run of empty reads on port 7 to saturate the counter.
        idle_inputs();
        rst = 1'b1;
        step();
        idle_inputs();
        req_in = 1'b1; addr_in = 3'd7;
        for (int n = 0; n < 300; n++) step();
        check("p7_underrun", underrun[7], 1'b1);
`ifdef IO_PORT_UNDERRUN_CNT_EN
        check("cnt_saturated", underrun_cnt, 8'd255);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/io_port_fl.md
IO_PORT_FL -- requirements
Module: io_port_fl

Interface
REQ-001 The module SHALL have parameter NBMANT, default 16, mantissa width of the processor word.
REQ-002 The module SHALL have parameter NBEXPO, default 6, exponent width; word width NBW = NBMANT+NBEXPO+1.
REQ-003 The module SHALL have parameter NUIOIN, default 8, number of processor input ports; AIW = $clog2(NUIOIN).
REQ-004 The module SHALL have parameter NUIOOU, default 8, number of processor output ports; AOW = $clog2(NUIOOU).
REQ-005 The module SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 The module SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 The module SHALL have port req_in  input  1  processor input-read request.
REQ-008 The module SHALL have port addr_in  input  AIW  processor input-port address.
REQ-009 The module SHALL have port io_in  output  NBW  read data returned to the processor.
REQ-010 The module SHALL have port out_en  input  1  processor output-write strobe.
REQ-011 The module SHALL have port addr_out  input  AOW  processor output-port address.
REQ-012 The module SHALL have port io_out  input  NBW  processor write data.
REQ-013 The module SHALL have port in_data  input  NUIOIN*NBW  producer words, port i at bits [i*NBW +: NBW].
REQ-014 The module SHALL have port in_valid  input  NUIOIN  producer valid, one bit per port.
REQ-015 The module SHALL have port in_ready  output  NUIOIN  buffer can accept, one bit per port.
REQ-016 The module SHALL have port out_data  output  NUIOOU*NBW  registered output words, port j at [j*NBW +: NBW].
REQ-017 The module SHALL have port out_valid  output  NUIOOU  one-cycle pulse per written port.
REQ-018 The module SHALL have port underrun  output  NUIOIN  sticky read-of-empty flags.

Function
REQ-019 Each input port i SHALL own a one-entry buffer buf[i] with flag full[i].
REQ-020 in_ready[i] SHALL equal ~rst & (~full[i] | consume[i]), consume[i] = req_in & (addr_in == i).
REQ-021 in_valid[i] & in_ready[i] SHALL load buf[i] <= in_data word i and set full[i] next cycle.
REQ-022 consume[i] without load SHALL clear full[i] next cycle; buf[i] SHALL keep its last value.
REQ-023 Simultaneous consume[i] and load SHALL leave full[i] = 1 with buf[i] = new word.
REQ-024 io_in SHALL be combinational buf[addr_in] (zero-latency read), independent of req_in.
REQ-025 consume[i] while full[i] = 0 SHALL return the stale buf[i] and set underrun[i] next cycle.
REQ-026 underrun bits SHALL be sticky until reset.
REQ-027 addr_in >= NUIOIN SHALL drive io_in = 0 and change no state.
REQ-028 out_en SHALL register io_out into out_data word addr_out and pulse out_valid[addr_out] high for exactly the next cycle (latency 1).
REQ-029 Back-to-back out_en to the same port SHALL produce consecutive pulses with each cycle's data.
REQ-030 addr_out >= NUIOOU SHALL be ignored (no data change, no pulse).
REQ-031 out_data words SHALL hold their value between writes.

Reset
REQ-032 rst SHALL clear every buf, full, out_data, out_valid and underrun bit to 0 on the next edge.
REQ-033 While rst = 1, in_ready SHALL be 0 and req_in/out_en SHALL be ignored; rst mid-transfer SHALL discard the buffered word.

Configuration
REQ-034 Macro IO_PORT_UNDERRUN_CNT_EN SHALL, when defined, add output underrun_cnt (8 bits), counting every underrun event of REQ-025, saturating at 255, cleared by rst.
REQ-035 Without IO_PORT_UNDERRUN_CNT_EN the port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-036 Reset, then in_valid[2]=1, in_data word2=0x12345A, next cycle addr_in=2, req_in=1 -> io_in=0x12345A, full[2] cleared, in_ready[2]=1.
REQ-037 Port 5 full with 0x000111, same cycle req_in@5 and in_valid[5] with 0x000222 -> full[5] stays 1, io_in@5 next cycle = 0x000222.
REQ-038 req_in@3 with port 3 empty after one consumed word 0x0000AA -> io_in=0x0000AA, underrun[3]=1 next cycle and stays 1; counter (macro on) = 1.
REQ-039 out_en=1, addr_out=6, io_out=0x7FFFFF -> next cycle out_valid=0x40 for one cycle, out_data word6=0x7FFFFF held afterwards.
REQ-040 Port 0 full, out_data word1 nonzero, rst=1 one cycle -> all outputs 0, in_ready=0 during rst, in_ready=all ones after.
REQ-041 300 underrun events with macro on -> underrun_cnt=255.
